// File: rtl/led_color_pkg.sv
// Shared types and colour helpers for the LED colour palette RAM.
// Colours are packed {G,B,R} with G in the most significant channel.
package led_color_pkg;

  localparam int CH_W_DEF = 8;
  localparam int CH_W_MAX = 16;

  typedef logic [CH_W_MAX-1:0]   chan_t;
  typedef logic [3*CH_W_MAX-1:0] color_wide_t;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } state_e;

  function automatic chan_t chan_max(input int ch_w);
    chan_t ones;
    ones = '1;
    return ones >> (CH_W_MAX - ch_w);
  endfunction

  // Channels are packed at ch_w spacing; callers keep the low 3*ch_w bits.
  function automatic color_wide_t pack_gbr(input chan_t g, input chan_t b,
                                           input chan_t r, input int ch_w);
    return (color_wide_t'(g) << (2 * ch_w)) | (color_wide_t'(b) << ch_w) | color_wide_t'(r);
  endfunction

  function automatic color_wide_t color_white(input int ch_w);
    return pack_gbr(chan_max(ch_w), chan_max(ch_w), chan_max(ch_w), ch_w);
  endfunction

  function automatic color_wide_t color_red(input int ch_w);
    return pack_gbr('0, '0, chan_max(ch_w), ch_w);
  endfunction

  function automatic color_wide_t color_off(input int ch_w);
    return pack_gbr('0, '0, '0, ch_w);
  endfunction

  function automatic color_wide_t color_green(input int ch_w);
    return pack_gbr(chan_max(ch_w), '0, '0, ch_w);
  endfunction

  function automatic color_wide_t color_teal(input int ch_w);
    return pack_gbr(chan_max(ch_w), chan_max(ch_w), '0, ch_w);
  endfunction

endpackage

// File: rtl/color_palette_ram_if.sv
// Bus between a palette client (master) and color_palette_ram (slave).
// Handshake: a read is accepted on a rising edge where rd_req && rd_ready;
// rd_valid pulses for exactly one cycle afterwards with rd_data/rd_oor.
interface color_palette_ram_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 24
);
  logic              init_start;
  logic              init_busy;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_req;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_oor;

  modport master (
    output init_start, wr_en, wr_addr, wr_data, rd_req, rd_addr,
    input  init_busy, rd_ready, rd_valid, rd_data, rd_oor
  );

  modport slave (
    input  init_start, wr_en, wr_addr, wr_data, rd_req, rd_addr,
    output init_busy, rd_ready, rd_valid, rd_data, rd_oor
  );
endinterface

// File: rtl/palette_default_rom.sv
// Combinational map from palette index to its power-on default colour.
module palette_default_rom
  import led_color_pkg::*;
#(
  parameter int CH_W   = CH_W_DEF,
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]  idx_i,
  output logic [3*CH_W-1:0]  color_o
);

  color_wide_t wide;
  logic        unused_hi;

  always_comb begin
    wide = color_off(CH_W);
    case (idx_i)
      ADDR_W'(0): wide = color_white(CH_W);
      ADDR_W'(1): wide = color_red(CH_W);
      ADDR_W'(3): wide = color_green(CH_W);
      ADDR_W'(4): wide = color_teal(CH_W);
      default:    wide = color_off(CH_W);
    endcase
  end

  assign color_o   = wide[3*CH_W-1:0];
  assign unused_hi = ^wide;

endmodule

// File: rtl/color_palette_ram.sv
// Palette RAM with a self-loading default table, 1-cycle read-first reads
// and out-of-range flagging; INIT walks every entry once, then serves IDLE.
module color_palette_ram
  import led_color_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int CH_W   = CH_W_DEF,
  parameter int ADDR_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  color_palette_ram_if.slave  bus,
  output state_e              state_o
);

  localparam int                DATA_W  = 3 * CH_W;
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W-1:0] k_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_oor_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rom_color;
  logic              idle;
  logic              rd_accept;
  logic              wr_accept;
  logic              rd_in_range;

  palette_default_rom #(
    .CH_W   (CH_W),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .idx_i   (k_q),
    .color_o (rom_color)
  );

  assign idle        = (state_q == IDLE);
  assign rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_V);
  assign rd_accept   = idle && bus.rd_req;
  assign wr_accept   = idle && bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_V);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= INIT;
      k_q        <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      rd_oor_q   <= 1'b0;
    end else begin
      rd_valid_q <= rd_accept;
      if (rd_accept) begin
        rd_data_q <= rd_in_range ? mem[bus.rd_addr] : '0;
        rd_oor_q  <= !rd_in_range;
      end
      case (state_q)
        INIT: begin
          if (k_q == LAST) begin
            state_q <= IDLE;
            k_q     <= '0;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        IDLE: begin
          if (bus.init_start) begin
            state_q <= INIT;
            k_q     <= '0;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end

  // Storage has no reset; the INIT walk defines its contents.
  always_ff @(posedge clk) begin
    if (!idle) begin
      mem[k_q] <= rom_color;
    end else if (wr_accept) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.init_busy = !idle;
  assign bus.rd_ready  = idle;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_oor    = rd_oor_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_color_palette_ram.sv
// Directed bench for color_palette_ram: a DEPTH=8 and a DEPTH=6 instance
// driven from a vector table plus hand-written reset/INIT sequences.
module tb_color_palette_ram;
  import led_color_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  color_palette_ram_if #(.ADDR_W(3), .DATA_W(24)) bus_a ();
  color_palette_ram_if #(.ADDR_W(3), .DATA_W(24)) bus_b ();
  state_e state_a;
  state_e state_b;

  color_palette_ram #(.DEPTH(8), .CH_W(8), .ADDR_W(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_o(state_a)
  );
  color_palette_ram #(.DEPTH(6), .CH_W(8), .ADDR_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_o(state_b)
  );

  typedef struct {
    logic        sel;        // 0 = DEPTH 8 instance, 1 = DEPTH 6 instance
    logic        rd_req;
    logic [2:0]  rd_addr;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [23:0] wr_data;
    logic        exp_valid;
    logic [23:0] exp_data;
    logic        exp_oor;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus_a.init_start = 1'b0; bus_a.wr_en = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_a.rd_req = 1'b0; bus_a.rd_addr = '0;
    bus_b.init_start = 1'b0; bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_b.rd_req = 1'b0; bus_b.rd_addr = '0;
  endtask

  task automatic read_a(input string name, input logic [2:0] addr, input logic [23:0] exp);
    bus_a.rd_req = 1'b1; bus_a.rd_addr = addr;
    tick();
    idle_inputs();
    chk({name, "_valid"}, {31'd0, bus_a.rd_valid}, 32'd1);
    chk({name, "_data"}, {8'd0, bus_a.rd_data}, {8'd0, exp});
  endtask

  // Counts edges until the DEPTH=8 instance leaves INIT (bounded).
  task automatic count_init_a(output int n);
    n = 0;
    while (bus_a.init_busy && n < 20) begin
      tick();
      n++;
    end
  endtask

  initial begin
    vec_t v;
    int   fa, fb, n;

    // sel rd a  wr a  wdata       v  data       oor
    vecs.push_back('{1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 24'h000000, 1'b1, 24'hFFFFFF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd1, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h0000FF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd2, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h000000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 24'h000000, 1'b1, 24'hFF0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 24'h000000, 1'b1, 24'hFFFF00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd7, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h000000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd4, 1'b0, 3'd0, 24'h000000, 1'b1, 24'hFFFF00, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 24'h000000, 1'b0, 24'hFFFF00, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 1'b1, 3'd3, 24'h123456, 1'b1, 24'hFF0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd3, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h123456, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 24'h0A0B0C, 1'b0, 24'h123456, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 3'd5, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h0A0B0C, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 3'd4, 1'b0, 3'd0, 24'h000000, 1'b1, 24'hFFFF00, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 3'd6, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h000000, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 3'd0, 1'b1, 3'd7, 24'hFFFFFF, 1'b0, 24'h000000, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h000000, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 3'd7, 1'b1, 3'd5, 24'h111111, 1'b1, 24'h000000, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 3'd5, 1'b0, 3'd0, 24'h000000, 1'b1, 24'h111111, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 3'd0, 1'b0, 3'd0, 24'h000000, 1'b1, 24'hFFFFFF, 1'b0});

    // Reset values, then length of the first INIT walk on both instances.
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_busy_a", {31'd0, bus_a.init_busy}, 32'd1);
    chk("rst_ready_a", {31'd0, bus_a.rd_ready}, 32'd0);
    chk("rst_valid_a", {31'd0, bus_a.rd_valid}, 32'd0);
    chk("rst_data_a", {8'd0, bus_a.rd_data}, 32'd0);
    chk("rst_oor_a", {31'd0, bus_a.rd_oor}, 32'd0);
    chk("rst_busy_b", {31'd0, bus_b.init_busy}, 32'd1);

    rst_n = 1'b1;
    fa = 0;
    fb = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (fa == 0 && !bus_a.init_busy) fa = c;
      if (fb == 0 && !bus_b.init_busy) fb = c;
      if (fa != 0 && fb != 0) break;
    end
    chk("init_len_a", fa, 8);
    chk("init_len_b", fb, 6);
    chk("ready_after_init_a", {31'd0, bus_a.rd_ready}, 32'd1);
    chk("state_after_init_a", {31'd0, state_a}, {31'd0, IDLE});

    // Back-to-back vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      if (!v.sel) begin
        bus_a.rd_req = v.rd_req; bus_a.rd_addr = v.rd_addr;
        bus_a.wr_en = v.wr_en; bus_a.wr_addr = v.wr_addr; bus_a.wr_data = v.wr_data;
      end else begin
        bus_b.rd_req = v.rd_req; bus_b.rd_addr = v.rd_addr;
        bus_b.wr_en = v.wr_en; bus_b.wr_addr = v.wr_addr; bus_b.wr_data = v.wr_data;
      end
      tick();
      idle_inputs();
      if (!v.sel) begin
        chk($sformatf("vec%0d_valid", i), {31'd0, bus_a.rd_valid}, {31'd0, v.exp_valid});
        chk($sformatf("vec%0d_data", i), {8'd0, bus_a.rd_data}, {8'd0, v.exp_data});
        chk($sformatf("vec%0d_oor", i), {31'd0, bus_a.rd_oor}, {31'd0, v.exp_oor});
      end else begin
        chk($sformatf("vec%0d_valid", i), {31'd0, bus_b.rd_valid}, {31'd0, v.exp_valid});
        chk($sformatf("vec%0d_data", i), {8'd0, bus_b.rd_data}, {8'd0, v.exp_data});
        chk($sformatf("vec%0d_oor", i), {31'd0, bus_b.rd_oor}, {31'd0, v.exp_oor});
      end
    end

    // Write + init_start + read in one IDLE cycle, then a full reload.
    bus_a.wr_en = 1'b1; bus_a.wr_addr = 3'd1; bus_a.wr_data = 24'hABCDEF;
    bus_a.init_start = 1'b1;
    bus_a.rd_req = 1'b1; bus_a.rd_addr = 3'd1;
    tick();
    idle_inputs();
    chk("start_rd_valid", {31'd0, bus_a.rd_valid}, 32'd1);
    chk("start_rd_data", {8'd0, bus_a.rd_data}, 32'h0000FF);
    chk("start_busy", {31'd0, bus_a.init_busy}, 32'd1);

    n = 0;
    while (bus_a.init_busy && n < 20) begin
      bus_a.rd_req = 1'b1; bus_a.rd_addr = 3'd1;
      bus_a.init_start = (n == 2);
      tick();
      n++;
      idle_inputs();
      chk($sformatf("init_rd_valid%0d", n), {31'd0, bus_a.rd_valid}, 32'd0);
    end
    chk("reload_len", n, 8);
    read_a("reload_e1", 3'd1, 24'h0000FF);
    read_a("reload_e3", 3'd3, 24'hFF0000);
    read_a("reload_e5", 3'd5, 24'h000000);

    // Reset during a pending read: async clear of every output.
    bus_a.rd_req = 1'b1; bus_a.rd_addr = 3'd0;
    tick();
    chk("pre_rst_valid", {31'd0, bus_a.rd_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, bus_a.rd_valid}, 32'd0);
    chk("arst_data", {8'd0, bus_a.rd_data}, 32'd0);
    chk("arst_oor", {31'd0, bus_a.rd_oor}, 32'd0);
    chk("arst_busy", {31'd0, bus_a.init_busy}, 32'd1);
    chk("arst_ready", {31'd0, bus_a.rd_ready}, 32'd0);
    tick();
    idle_inputs();
    chk("rst_hold_valid", {31'd0, bus_a.rd_valid}, 32'd0);
    rst_n = 1'b1;
    count_init_a(n);
    chk("init_len_after_rd_rst", n, 8);

    // Reset at INIT k=4 must restart the walk from entry 0.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("k4_busy", {31'd0, bus_a.init_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("k4_arst_state", {31'd0, state_a}, {31'd0, INIT});
    tick();
    rst_n = 1'b1;
    count_init_a(n);
    chk("init_len_after_k4_rst", n, 8);
    read_a("post_rst_e4", 3'd4, 24'hFFFF00);
    read_a("post_rst_e0", 3'd0, 24'hFFFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/color_palette_ram.md
COLOR_PALETTE_RAM -- requirements
Module: color_palette_ram

Interface
REQ-001 Parameter DEPTH, default 8, number of palette entries; SHALL be >= 5.
REQ-002 Parameter CH_W, default 8, bits per colour channel; DATA_W SHALL equal 3*CH_W.
REQ-003 Parameter ADDR_W, default 3, address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 init_start  input  1  pulse; requests reload of default contents.
REQ-007 init_busy  output  1  high while the default-load sequence runs.
REQ-008 wr_en  input  1  write strobe.
REQ-009 wr_addr  input  ADDR_W  write address.
REQ-010 wr_data  input  DATA_W  write colour, packed {G,B,R}, G in the MSBs.
REQ-011 rd_req  input  1  read request; accepted only when rd_ready=1.
REQ-012 rd_ready  output  1  equals !init_busy.
REQ-013 rd_addr  input  ADDR_W  read address.
REQ-014 rd_valid  output  1  one-cycle pulse marking rd_data/rd_oor valid.
REQ-015 rd_data  output  DATA_W  registered read colour.
REQ-016 rd_oor  output  1  read address was >= DEPTH.

Function
REQ-017 Default table: entry 0 white (all ones), 1 red (R max), 2 off (zero), 3 green (G max), 4 teal (G and B max), 5..DEPTH-1 off; max = all ones in a CH_W-bit channel.
REQ-018 The FSM SHALL have two states: INIT and IDLE.
REQ-019 INIT: write the default for entry k in cycle k, k = 0..DEPTH-1; after entry DEPTH-1, go to IDLE.
REQ-020 init_busy SHALL be 1 in INIT and 0 in IDLE.
REQ-021 In IDLE, init_start=1 SHALL restart INIT at k=0 on the next cycle; in INIT, init_start SHALL be ignored.
REQ-022 In INIT, wr_en and rd_req SHALL be ignored, and rd_valid SHALL be 0.
REQ-023 In IDLE, wr_en with wr_addr < DEPTH SHALL update the entry at the clock edge; wr_addr >= DEPTH SHALL be dropped silently.
REQ-024 Read latency SHALL be 1 cycle: an accepted rd_req at edge N gives rd_valid=1 with data after edge N+1-equivalent register, i.e. visible in the cycle after acceptance.
REQ-025 rd_valid SHALL be 0 in any cycle that does not follow an accepted request; rd_data and rd_oor SHALL hold their last values.
REQ-026 Read and write to the same address in the same cycle SHALL return the old contents (read-first).
REQ-027 A read with rd_addr >= DEPTH SHALL return rd_data=0 and rd_oor=1; otherwise rd_oor=0.
REQ-028 Back-to-back rd_req SHALL be accepted every cycle in IDLE (full throughput).
REQ-029 If init_start and wr_en are both high in IDLE, the write SHALL complete, then INIT SHALL overwrite it.

Reset
REQ-030 On rst_n low, the FSM SHALL enter INIT with k=0 immediately and asynchronously.
REQ-031 Reset values SHALL be: init_busy=1, rd_ready=0, rd_valid=0, rd_data=0, rd_oor=0.
REQ-032 Reset mid-INIT or mid-read SHALL abort the operation; the pending rd_valid SHALL be lost.
REQ-033 Storage SHALL not be reset directly; the INIT sequence after reset SHALL define its contents.

Structure
REQ-034 Package led_color_pkg SHALL hold: the CH_W default, the colour constants (WHITE, RED, OFF, GREEN, TEAL) as functions of CH_W, the {G,B,R} packing helper, and the state enum (INIT, IDLE).
REQ-035 Sub-module palette_default_rom SHALL map an entry index to its default colour (combinational); the FSM SHALL drive it with k.

Verification (DEPTH=8, CH_W=8 unless stated)
REQ-036 Release reset -> init_busy=1 for exactly 8 cycles, then 0; rd_ready rises in the same cycle.
REQ-037 Read addresses 0..4 and 7 back-to-back -> rd_valid on 6 consecutive cycles with FFFFFF, 0000FF, 000000, FF0000, FFFF00, 000000.
REQ-038 Write 3=123456 with simultaneous read 3 -> FF0000; read 3 next -> 123456.
REQ-039 Write 1=ABCDEF, pulse init_start, wait for init_busy to fall, read 1 -> 0000FF; rd_req during INIT -> no rd_valid.
REQ-040 DEPTH=6: read 6 -> rd_data=000000, rd_oor=1; write 7=FFFFFF then read 5 -> 000000.
REQ-041 Assert rst_n low at INIT k=4 and at a pending read -> outputs at reset values immediately; full 8-cycle INIT repeats after release.
